// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle RV32I controller: state encodings,
// opcodes, ALUControl codes, mux-select encodings and the per-state control word.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMM       = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      alu_op_t    alu_op;
   } ctrl_t;

   // Moore control word for each state; anything not set stays 0 / add.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      c.alu_op = ALUOP_ADD;
      case (s)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.pc_write   = 1'b1;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURESULT;
         end
         S_DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD:  c.adr_src = 1'b1;
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECR: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_RD2;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB:    c.reg_write = 1'b1;
         S_BRANCH: begin
            // pc_write here is decided from Zero at the top level
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_RD2;
            c.alu_op    = ALUOP_SUB;
         end
         S_JAL: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_FOUR;
            c.pc_write  = 1'b1;
         end
         S_LUI: begin
            c.result_src = RES_IMM;
            c.reg_write  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
             (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL) ||
             (op == OP_LUI);
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: turns the controller's ALUOp plus instruction
// function bits into the 4-bit ALUControl code.
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [3:0] alu_control
);

   // op5 separates R-type (sub possible) from I-type (addi never subtracts)
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback and
// drives the datapath selects, write enables and ALUControl.
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic       IllegalOp,
   output logic [3:0] State
);

   state_t state;
   state_t next_state;
   ctrl_t  ctrl_q;
   logic   state_valid;
   logic   write_ok;
   logic   branch_taken;

   // Next-state selection from the current state and opcode
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH: next_state = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: next_state = S_MEMADR;
               OP_RTYPE:          next_state = S_EXECR;
               OP_ITYPE:          next_state = S_EXECI;
               OP_BRANCH:         next_state = S_BRANCH;
               OP_JAL:            next_state = S_JAL;
               OP_LUI:            next_state = S_LUI;
               default:           next_state = S_FETCH;
            endcase
         end
         S_MEMADR:   next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  next_state = S_MEMWB;
         S_EXECR:    next_state = S_ALUWB;
         S_EXECI:    next_state = S_ALUWB;
         S_JAL:      next_state = S_ALUWB;
         default:    next_state = S_FETCH;
      endcase
   end

   // State register with the control word registered alongside it
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_FETCH;
         ctrl_q <= state_ctrl(S_FETCH);
      end else begin
         state  <= next_state;
         ctrl_q <= state_ctrl(next_state);
      end
   end

   // Enables are suppressed in reset and in any undefined state encoding
   assign state_valid  = (state <= S_LUI);
   assign write_ok     = ~reset & state_valid;
   assign branch_taken = ((funct3 == 3'b000) &  Zero) |
                         ((funct3 == 3'b001) & ~Zero);

   assign PCWrite   = write_ok & ((state == S_BRANCH) ? branch_taken : ctrl_q.pc_write);
   assign MemWrite  = write_ok & ctrl_q.mem_write;
   assign IRWrite   = write_ok & ctrl_q.ir_write;
   assign RegWrite  = write_ok & ctrl_q.reg_write;
   assign AdrSrc    = ctrl_q.adr_src;
   assign ResultSrc = ctrl_q.result_src;
   assign ALUSrcA   = ctrl_q.alu_src_a;
   assign ALUSrcB   = ctrl_q.alu_src_b;
   assign IllegalOp = (state == S_DECODE) & ~is_legal_op(op);
   assign State     = state;

   // Immediate format depends on the opcode alone
   always_comb begin
      ImmSrc = IMM_I;
      case (op)
         OP_STORE:  ImmSrc = IMM_S;
         OP_BRANCH: ImmSrc = IMM_B;
         OP_JAL:    ImmSrc = IMM_J;
         OP_LUI:    ImmSrc = IMM_U;
         default:   ImmSrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (ctrl_q.alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded by a
// reference model into its expected per-cycle output vectors.
module tb_multicycle_controller;
   import multicycle_controller_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl, State;

   int n_checks = 0;
   int n_fail   = 0;

   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,IllegalOp,State}
   logic [22:0] exp_q[$];

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .IllegalOp(IllegalOp), .State(State)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [22:0] observed();
      return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
              ALUSrcB, ImmSrc, ALUControl, IllegalOp, State};
   endfunction

   function automatic logic [22:0] mk(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw,
                                      input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [2:0] imm,
                                      input logic [3:0] ac, input logic ill,
                                      input logic [3:0] st);
      return {pcw, adr, mw, irw, rw, rs, a, b, imm, ac, ill, st};
   endfunction

   function automatic logic known_op(input logic [6:0] o);
      return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                       7'b1100011, 7'b1101111, 7'b0110111};
   endfunction

   // ALU operation an instruction asks for, by mnemonic meaning
   function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
      case (f3)
         3'd0: return (is_r && f7) ? 4'b0001 : 4'b0000;
         3'd1: return 4'b0010;
         3'd2: return 4'b0011;
         3'd3: return 4'b0100;
         3'd4: return 4'b0101;
         3'd5: return f7 ? 4'b0111 : 4'b0110;
         3'd6: return 4'b1000;
         default: return 4'b1001;
      endcase
   endfunction

   // Reference model: expected outputs for every cycle of one instruction
   task automatic build_expect(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z);
      logic [2:0] imm;
      logic       taken;
      case (o)
         7'b0100011: imm = 3'b001;
         7'b1100011: imm = 3'b010;
         7'b1101111: imm = 3'b011;
         7'b0110111: imm = 3'b100;
         default:    imm = 3'b000;
      endcase
      exp_q.push_back(mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 4'b0000, 0, S_FETCH));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 4'b0000, !known_op(o), S_DECODE));
      case (o)
         7'b0000011: begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 4'b0000, 0, S_MEMADR));
            exp_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 4'b0000, 0, S_MEMREAD));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, 4'b0000, 0, S_MEMWB));
         end
         7'b0100011: begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 4'b0000, 0, S_MEMADR));
            exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 4'b0000, 0, S_MEMWRITE));
         end
         7'b0110011: begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, ref_alu(f3, f7, 1'b1), 0, S_EXECR));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 4'b0000, 0, S_ALUWB));
         end
         7'b0010011: begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, ref_alu(f3, f7, 1'b0), 0, S_EXECI));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 4'b0000, 0, S_ALUWB));
         end
         7'b1100011: begin
            taken = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? !z : 1'b0);
            exp_q.push_back(mk(taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 4'b0001, 0, S_BRANCH));
         end
         7'b1101111: begin
            exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 4'b0000, 0, S_JAL));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 4'b0000, 0, S_ALUWB));
         end
         7'b0110111: begin
            exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, imm, 4'b0000, 0, S_LUI));
         end
         default: ;
      endcase
   endtask

   // Driver: called during a FETCH cycle, returns during the next FETCH cycle
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input string name);
      logic [22:0] got;
      logic [22:0] exp;
      int          n;
      op = o; funct3 = f3; funct7b5 = f7; Zero = z;
      exp_q.delete();
      build_expect(o, f3, f7, z);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         got = observed();
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, exp);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (State !== S_FETCH) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected %0d", State, S_FETCH);
      end
      n_checks++;
      if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_enables: got %b expected 0000", {PCWrite, MemWrite, IRWrite, RegWrite});
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (observed() !== mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 0, S_FETCH)) begin
         n_fail++;
         $display("FAIL reset_fetch_outputs: got %h", observed());
      end
   endtask

   task automatic test_alu_ops();
      run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, "add");
      run_instr(7'b0110011, 3'b000, 1'b1, 1'b1, "sub");
      run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, "addi_b30");
      run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, "srai");
      run_instr(7'b0010011, 3'b101, 1'b0, 1'b1, "srli");
      run_instr(7'b0110011, 3'b101, 1'b1, 1'b0, "sra");
      for (int i = 0; i < 8; i++)
         run_instr(7'b0110011, i[2:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "r_funct");
      for (int i = 0; i < 8; i++)
         run_instr(7'b0010011, i[2:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "i_funct");
   endtask

   task automatic test_load_store();
      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, "lw");
      run_instr(7'b0100011, 3'b010, 1'b0, 1'b1, "sw");
      run_instr(7'b0000011, 3'b010, 1'b1, 1'b1, "lw_zero");
   endtask

   task automatic test_branch();
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, "beq_taken");
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, "beq_not");
      run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, "bne_taken");
      run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, "bne_not");
      run_instr(7'b1100011, 3'b100, 1'b0, 1'b1, "blt_unsup_z1");
      run_instr(7'b1100011, 3'b110, 1'b0, 1'b0, "bltu_unsup_z0");
   endtask

   task automatic test_jal_lui();
      run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, "jal");
      run_instr(7'b0110111, 3'b011, 1'b1, 1'b1, "lui");
   endtask

   task automatic test_illegal();
      logic [6:0] o;
      run_instr(7'b0000000, 3'b000, 1'b0, 1'b1, "illegal_zero");
      for (int i = 0; i < 4; i++) begin
         o = 7'($urandom_range(0, 127));
         for (int t = 0; t < 20 && known_op(o); t++) o = 7'($urandom_range(0, 127));
         if (known_op(o)) o = 7'b1111111;
         run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "illegal_rand");
      end
   endtask

   task automatic test_reset_mid();
      op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (State !== S_MEMWRITE || MemWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_reach_memwrite: got state %0d memwrite %b expected %0d 1", State, MemWrite, S_MEMWRITE);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_reset_memwrite_blocked: got %b expected 0000", {PCWrite, MemWrite, IRWrite, RegWrite});
      end
      @(posedge clk); #1;
      n_checks++;
      if (State !== S_FETCH) begin
         n_fail++;
         $display("FAIL mid_reset_to_fetch: got %0d expected %0d", State, S_FETCH);
      end
      reset = 1'b0;
      // same again with a taken branch
      op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      n_checks++;
      if (State !== S_BRANCH || PCWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_reach_branch: got state %0d pcwrite %b expected %0d 1", State, PCWrite, S_BRANCH);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (PCWrite !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_pcwrite_blocked: got %b expected 0", PCWrite);
      end
      @(posedge clk); #1;
      n_checks++;
      if (State !== S_FETCH) begin
         n_fail++;
         $display("FAIL mid_reset_branch_to_fetch: got %0d expected %0d", State, S_FETCH);
      end
      reset = 1'b0;
      #1;
   endtask

   task automatic test_random();
      logic [6:0] ops[8];
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
              7'b1100011, 7'b1101111, 7'b0110111, 7'b0001111};
      for (int i = 0; i < 60; i++)
         run_instr(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
      @(negedge clk);
      n_checks++;
      if (State !== S_FETCH) begin
         n_fail++;
         $display("FAIL final_fetch: got %0d expected %0d", State, S_FETCH);
      end
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_load_store();
      test_branch();
      test_jal_lui();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
